// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage interlock, flush and interrupt-boundary control for the 5-stage core.
// Covers load-use with configurable latency, ID branch operand hazards, mul/div busy and a saturating stall counter.
module hazard_ctrl #(
    parameter int RA_W     = 5,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RA_W-1:0]  rs_id,
    input  logic [RA_W-1:0]  rt_id,
    input  logic             branch_id,
    input  logic [2:0]       pc_src_id,
    input  logic             md_start_id,
    input  logic             md_use_id,
    input  logic             mem_read_ex,
    input  logic [RA_W-1:0]  rt_ex,
    input  logic             reg_write_ex,
    input  logic [RA_W-1:0]  wa_ex,
    input  logic             mem_read_mem,
    input  logic [RA_W-1:0]  wa_mem,
    input  logic             irq_req,
    input  logic             irq_en,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic             irq_take,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count
);
    localparam int LW = LOAD_LAT > 1 ? $clog2(LOAD_LAT) : 1;
    localparam int MW = $clog2(MD_LAT + 1);

    logic [LW-1:0] ld_cnt;
    logic [MW-1:0] md_cnt;
    logic          irq_pend;
    logic          lu, bx, bm, md;

    // Outputs are forced low while reset is held, whatever the pipeline presents.
    always_comb begin
        lu       = mem_read_ex && rt_ex != '0 && (rt_ex == rs_id || rt_ex == rt_id);
        bx       = branch_id && reg_write_ex && wa_ex != '0 && (wa_ex == rs_id || wa_ex == rt_id);
        bm       = branch_id && mem_read_mem && wa_mem != '0 && (wa_mem == rs_id || wa_mem == rt_id);
        md       = md_use_id && md_cnt != '0;
        stall    = !reset && (lu || bx || bm || md || ld_cnt != '0);
        bubble   = stall;
        md_busy  = !reset && md_cnt != '0;
        irq_take = !reset && irq_pend && !stall && !md_busy;
        flush    = (!reset && pc_src_id != 3'd0 && !stall) || irq_take;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_cnt      <= '0;
            md_cnt      <= '0;
            irq_pend    <= 1'b0;
            stall_count <= '0;
        end else begin
            ld_cnt   <= ld_cnt != '0 ? ld_cnt - LW'(1) : (lu ? LW'(LOAD_LAT - 1) : '0);
            md_cnt   <= (md_start_id && !stall) ? MW'(MD_LAT) : (md_cnt != '0 ? md_cnt - MW'(1) : '0);
            irq_pend <= irq_take ? 1'b0 : (irq_pend || (irq_req && irq_en));
            if (stall && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl; DUT a uses LOAD_LAT=1/CNT_W=16, DUT b uses LOAD_LAT=3/CNT_W=3.
module tb_hazard_ctrl;
    logic clk = 0;
    logic reset;
    logic [4:0] rs_id, rt_id, rt_ex, wa_ex, wa_mem;
    logic branch_id, md_start_id, md_use_id, mem_read_ex, reg_write_ex, mem_read_mem, irq_req, irq_en;
    logic [2:0] pc_src_id;
    logic a_stall, a_bubble, a_flush, a_irq_take, a_md_busy;
    logic b_stall, b_bubble, b_flush, b_irq_take, b_md_busy;
    logic [15:0] a_cnt;
    logic [2:0]  b_cnt;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_LAT(1), .MD_LAT(8), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id), .branch_id(branch_id),
        .pc_src_id(pc_src_id), .md_start_id(md_start_id), .md_use_id(md_use_id),
        .mem_read_ex(mem_read_ex), .rt_ex(rt_ex), .reg_write_ex(reg_write_ex), .wa_ex(wa_ex),
        .mem_read_mem(mem_read_mem), .wa_mem(wa_mem), .irq_req(irq_req), .irq_en(irq_en),
        .stall(a_stall), .bubble(a_bubble), .flush(a_flush), .irq_take(a_irq_take),
        .md_busy(a_md_busy), .stall_count(a_cnt));

    hazard_ctrl #(.LOAD_LAT(3), .MD_LAT(8), .CNT_W(3)) u_b (
        .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id), .branch_id(branch_id),
        .pc_src_id(pc_src_id), .md_start_id(md_start_id), .md_use_id(md_use_id),
        .mem_read_ex(mem_read_ex), .rt_ex(rt_ex), .reg_write_ex(reg_write_ex), .wa_ex(wa_ex),
        .mem_read_mem(mem_read_mem), .wa_mem(wa_mem), .irq_req(irq_req), .irq_en(irq_en),
        .stall(b_stall), .bubble(b_bubble), .flush(b_flush), .irq_take(b_irq_take),
        .md_busy(b_md_busy), .stall_count(b_cnt));

    task automatic clear_in();
        {rs_id, rt_id, rt_ex, wa_ex, wa_mem} = '0;
        {branch_id, md_start_id, md_use_id, mem_read_ex, reg_write_ex, mem_read_mem, irq_req, irq_en} = '0;
        pc_src_id = 3'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        clear_in();
        reset = 1;
        mem_read_ex = 1; rt_ex = 5'd8; rs_id = 5'd8; pc_src_id = 3'd2; irq_req = 1; irq_en = 1; md_start_id = 1;
        tick();
        tick();
        checks++;
        if ({a_stall, a_bubble, a_flush, a_irq_take, a_md_busy} !== 5'b0) begin
            errors++; $display("FAIL reset_outs got %b want 00000", {a_stall, a_bubble, a_flush, a_irq_take, a_md_busy});
        end
        checks++;
        if (a_cnt !== 16'd0 || b_cnt !== 3'd0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", a_cnt, b_cnt);
        end
        clear_in();
        reset = 0;
        #1;
        checks++;
        if (a_irq_take !== 1'b0 || a_md_busy !== 1'b0) begin
            errors++; $display("FAIL reset_release got irq_take=%b md_busy=%b want 0 0", a_irq_take, a_md_busy);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        mem_read_ex = 1; rt_ex = 5'd0; rs_id = 5'd0;
        #1;
        checks++;
        if (a_stall !== 1'b0) begin errors++; $display("FAIL lu_r0 got %b want 0", a_stall); end
        rt_ex = 5'd8; rs_id = 5'd3; rt_id = 5'd8;
        #1;
        checks++;
        if (a_stall !== 1'b1) begin errors++; $display("FAIL lu_rt got %b want 1", a_stall); end
        rt_id = 5'd0; rs_id = 5'd8;
        #1;
        checks++;
        if ({a_stall, a_bubble, a_flush} !== 3'b110 || b_stall !== 1'b1) begin
            errors++; $display("FAIL lu_t1 got a=%b b_stall=%b want 110 1", {a_stall, a_bubble, a_flush}, b_stall);
        end
        tick();
        clear_in();
        #1;
        checks++;
        if (a_stall !== 1'b0 || b_stall !== 1'b1) begin
            errors++; $display("FAIL lu_c1 got a=%b b=%b want 0 1", a_stall, b_stall);
        end
        tick();
        checks++;
        if (b_stall !== 1'b1 || b_bubble !== 1'b1) begin errors++; $display("FAIL lu_c2 got %b%b want 11", b_stall, b_bubble); end
        tick();
        checks++;
        if (b_stall !== 1'b0) begin errors++; $display("FAIL lu_c3 got %b want 0", b_stall); end
        checks++;
        if (a_cnt !== 16'd1 || b_cnt !== 3'd3) begin
            errors++; $display("FAIL lu_cnt got %0d/%0d want 1/3", a_cnt, b_cnt);
        end
    endtask

    task automatic test_branch();
        do_reset();
        branch_id = 1; reg_write_ex = 1; wa_ex = 5'd0; rs_id = 5'd0;
        #1;
        checks++;
        if (a_stall !== 1'b0) begin errors++; $display("FAIL br_r0 got %b want 0", a_stall); end
        wa_ex = 5'd5; rt_id = 5'd5; pc_src_id = 3'd2;
        #1;
        checks++;
        if (a_stall !== 1'b1 || a_flush !== 1'b0) begin
            errors++; $display("FAIL br_stall got stall=%b flush=%b want 1 0", a_stall, a_flush);
        end
        tick();
        reg_write_ex = 0;
        #1;
        checks++;
        if (a_stall !== 1'b0 || a_flush !== 1'b1) begin
            errors++; $display("FAIL br_flush got stall=%b flush=%b want 0 1", a_stall, a_flush);
        end
        pc_src_id = 3'd0; mem_read_mem = 1; wa_mem = 5'd7; rs_id = 5'd7;
        #1;
        checks++;
        if (a_stall !== 1'b1) begin errors++; $display("FAIL br_mem got %b want 1", a_stall); end
        branch_id = 0;
        #1;
        checks++;
        if (a_stall !== 1'b0) begin errors++; $display("FAIL br_mem_nobr got %b want 0", a_stall); end
        clear_in();
    endtask

    task automatic test_muldiv();
        do_reset();
        md_start_id = 1; md_use_id = 1;
        #1;
        checks++;
        if (a_stall !== 1'b0 || a_md_busy !== 1'b0) begin
            errors++; $display("FAIL md_start got stall=%b busy=%b want 0 0", a_stall, a_md_busy);
        end
        tick();
        md_start_id = 0;
        for (int i = 0; i < 8; i++) begin
            if (i >= 3) md_start_id = 1;
            #1;
            checks++;
            if (a_stall !== 1'b1 || a_md_busy !== 1'b1) begin
                errors++; $display("FAIL md_busy_%0d got stall=%b busy=%b want 1 1", i, a_stall, a_md_busy);
            end
            tick();
        end
        md_start_id = 0;
        #1;
        checks++;
        if (a_stall !== 1'b0 || a_md_busy !== 1'b0) begin
            errors++; $display("FAIL md_done got stall=%b busy=%b want 0 0", a_stall, a_md_busy);
        end
        checks++;
        if (a_cnt !== 16'd8 || b_cnt !== 3'd7) begin
            errors++; $display("FAIL md_cnt got %0d/%0d want 8/7", a_cnt, b_cnt);
        end
        clear_in();
    endtask

    task automatic test_irq();
        do_reset();
        md_start_id = 1;
        tick();
        md_start_id = 0; irq_req = 1; irq_en = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (a_irq_take !== 1'b0 || a_md_busy !== 1'b1) begin
                errors++; $display("FAIL irq_wait_%0d got take=%b busy=%b want 0 1", i, a_irq_take, a_md_busy);
            end
            tick();
            irq_req = 0; irq_en = 0;
        end
        mem_read_ex = 1; rt_ex = 5'd4; rs_id = 5'd4;
        #1;
        checks++;
        if (a_irq_take !== 1'b0 || a_flush !== 1'b0) begin
            errors++; $display("FAIL irq_stalled got take=%b flush=%b want 0 0", a_irq_take, a_flush);
        end
        mem_read_ex = 0; irq_req = 1; irq_en = 1;
        #1;
        checks++;
        if (a_irq_take !== 1'b1 || a_flush !== 1'b1) begin
            errors++; $display("FAIL irq_take got take=%b flush=%b want 1 1", a_irq_take, a_flush);
        end
        tick();
        checks++;
        if (a_irq_take !== 1'b0 || a_flush !== 1'b0) begin
            errors++; $display("FAIL irq_clear got take=%b flush=%b want 0 0", a_irq_take, a_flush);
        end
        tick();
        irq_req = 0;
        #1;
        checks++;
        if (a_irq_take !== 1'b1) begin errors++; $display("FAIL irq_again got %b want 1", a_irq_take); end
        tick();
        checks++;
        if (a_irq_take !== 1'b0) begin errors++; $display("FAIL irq_end got %b want 0", a_irq_take); end
        clear_in();
    endtask

    task automatic test_reset_mid();
        do_reset();
        md_start_id = 1;
        tick();
        md_start_id = 0; mem_read_ex = 1; rt_ex = 5'd9; rt_id = 5'd9;
        tick();
        clear_in();
        md_use_id = 1;
        #1;
        checks++;
        if (b_stall !== 1'b1 || a_md_busy !== 1'b1) begin
            errors++; $display("FAIL mid_pre got stall=%b busy=%b want 1 1", b_stall, a_md_busy);
        end
        reset = 1;
        #1;
        checks++;
        if (b_stall !== 1'b0 || a_stall !== 1'b0 || a_md_busy !== 1'b0) begin
            errors++; $display("FAIL mid_rst got %b%b%b want 000", b_stall, a_stall, a_md_busy);
        end
        tick();
        reset = 0;
        #1;
        checks++;
        if (b_stall !== 1'b0 || a_stall !== 1'b0 || b_md_busy !== 1'b0 || b_cnt !== 3'd0) begin
            errors++; $display("FAIL mid_after got stall=%b/%b busy=%b cnt=%0d want 0/0 0 0", a_stall, b_stall, b_md_busy, b_cnt);
        end
        clear_in();
    endtask

    initial begin
        clear_in();
        reset = 1;
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv();
        test_irq();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
